// File: rtl/zynet_frame_sequencer_pkg.sv
// Shared types and defaults for the zyNet frame sequencer.
// Contents:
//   seq_state_e  - sequencer FSM state encoding
//   DEF_*        - default parameter values used by the top, interface and watchdog
//   word_idx(j)  - bit offset of result word j inside a packed result vector
package zynet_seq_pkg;

    localparam int DEF_WORD_SIZE           = 16;
    localparam int DEF_INPUT_LAYER_HEIGHT  = 265;
    localparam int DEF_OUTPUT_LAYER_HEIGHT = 10;
    localparam int DEF_TIMEOUT_CYCLES      = 65535;
    localparam int DEF_CNT_WIDTH           = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM,
        ST_WAIT,
        ST_DELIVER,
        ST_ERROR
    } seq_state_e;

    function automatic int word_idx(input int j, input int ws = DEF_WORD_SIZE);
        return j * ws;
    endfunction

endpackage

// File: rtl/zynet_frame_sequencer_if.sv
// Signal bundle around the frame sequencer: upstream sample stream, zyNet core
// side, downstream result side and status.
// Modports:
//   master - the sequencer (drives s_ready_o, net_*_o, res_*_o, status)
//   slave  - the environment (upstream source, core, consumer)
interface zynet_frame_sequencer_if
    import zynet_seq_pkg::*;
#(
    parameter int WORD_SIZE           = DEF_WORD_SIZE,
    parameter int OUTPUT_LAYER_HEIGHT = DEF_OUTPUT_LAYER_HEIGHT,
    parameter int CNT_WIDTH           = DEF_CNT_WIDTH
);
    logic                                     en_i;
    logic                                     clear_i;
    logic [WORD_SIZE-1:0]                     s_data_i;
    logic                                     s_valid_i;
    logic                                     s_ready_o;
    logic                                     net_start_o;
    logic [WORD_SIZE-1:0]                     net_data_o;
    logic                                     net_valid_o;
    logic                                     net_ready_i;
    logic [OUTPUT_LAYER_HEIGHT*WORD_SIZE-1:0] net_data_i;
    logic                                     net_valid_i;
    logic                                     net_yumi_o;
    logic [OUTPUT_LAYER_HEIGHT*WORD_SIZE-1:0] res_data_o;
    logic                                     res_valid_o;
    logic                                     res_yumi_i;
    logic                                     busy_o;
    logic                                     error_o;
    logic [CNT_WIDTH-1:0]                     frame_count_o;

    modport master (
        input  en_i, clear_i, s_data_i, s_valid_i, net_ready_i, net_data_i,
               net_valid_i, res_yumi_i,
        output s_ready_o, net_start_o, net_data_o, net_valid_o, net_yumi_o,
               res_data_o, res_valid_o, busy_o, error_o, frame_count_o
    );

    modport slave (
        output en_i, clear_i, s_data_i, s_valid_i, net_ready_i, net_data_i,
               net_valid_i, res_yumi_i,
        input  s_ready_o, net_start_o, net_data_o, net_valid_o, net_yumi_o,
               res_data_o, res_valid_o, busy_o, error_o, frame_count_o
    );

endinterface

// File: rtl/zynet_frame_sequencer_watchdog.sv
// Watchdog counter for the sequencer's WAIT state.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   clear      - zero the count (wins over enable)
//   enable     - count up by one this cycle
//   tc         - count has reached TIMEOUT_CYCLES-1
module zynet_seq_watchdog
    import zynet_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign tc = (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/zynet_frame_sequencer.sv
// Frame-level controller for one zyNet inference per input frame: pulses the
// core start, gates exactly INPUT_LAYER_HEIGHT words into the core, waits for
// the result under a watchdog, captures and acknowledges it, then holds it for
// the downstream consumer.
// Ports:
//   clk_i, reset_i - clock and synchronous active-high reset
//   bus            - master side of zynet_frame_sequencer_if (stream, core,
//                    result and status signals)
//
// state   | meaning
// IDLE    | waiting for en_i & s_valid_i
// START   | one-cycle net_start_o pulse
// STREAM  | pass-through of input words to the core, counting transfers
// WAIT    | waiting for the core result, watchdog running
// DELIVER | result held for the consumer until res_yumi_i
// ERROR   | watchdog expired, held until clear_i
module zynet_frame_sequencer
    import zynet_seq_pkg::*;
#(
    parameter int WORD_SIZE           = DEF_WORD_SIZE,
    parameter int INPUT_LAYER_HEIGHT  = DEF_INPUT_LAYER_HEIGHT,
    parameter int OUTPUT_LAYER_HEIGHT = DEF_OUTPUT_LAYER_HEIGHT,
    parameter int TIMEOUT_CYCLES      = DEF_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH           = DEF_CNT_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    zynet_frame_sequencer_if.master  bus
);
    localparam int WC    = $clog2(INPUT_LAYER_HEIGHT + 1);
    localparam int RES_W = OUTPUT_LAYER_HEIGHT * WORD_SIZE;

    seq_state_e           state_q, state_d;
    logic [WC-1:0]        word_cnt_q;
    logic [RES_W-1:0]     res_q;
    logic [CNT_WIDTH-1:0] frame_cnt_q;
    logic                 xfer, last_xfer, capture, wd_tc;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        xfer      = 1'b0;
        last_xfer = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.en_i && bus.s_valid_i) state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                xfer = bus.s_valid_i && bus.net_ready_i;
                if (xfer && (word_cnt_q == WC'(INPUT_LAYER_HEIGHT - 1))) begin
                    last_xfer = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A result arriving on the terminal-count cycle still wins.
                if (bus.net_valid_i) begin
                    capture = 1'b1;
                    state_d = ST_DELIVER;
                end else if (wd_tc) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DELIVER: begin
                if (bus.res_yumi_i) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (bus.clear_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            word_cnt_q  <= '0;
            res_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (last_xfer) begin
                word_cnt_q <= '0;
            end else if (xfer) begin
                word_cnt_q <= word_cnt_q + WC'(1);
            end
            if (capture) begin
                res_q <= bus.net_data_i;
            end
            if (state_q == ST_DELIVER && bus.res_yumi_i) begin
                frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    zynet_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk_i),
        .reset  (reset_i),
        .clear  (last_xfer),
        .enable (state_q == ST_WAIT),
        .tc     (wd_tc)
    );

    assign bus.s_ready_o     = (state_q == ST_STREAM) && bus.net_ready_i;
    assign bus.net_valid_o   = (state_q == ST_STREAM) && bus.s_valid_i;
    assign bus.net_data_o    = (state_q == ST_STREAM) ? bus.s_data_i : '0;
    assign bus.net_start_o   = (state_q == ST_START);
    assign bus.net_yumi_o    = capture;
    assign bus.res_data_o    = res_q;
    assign bus.res_valid_o   = (state_q == ST_DELIVER);
    assign bus.busy_o        = (state_q != ST_IDLE);
    assign bus.error_o       = (state_q == ST_ERROR);
    assign bus.frame_count_o = frame_cnt_q;

endmodule

// File: tb/tb_zynet_frame_sequencer.sv
// Directed bench for zynet_frame_sequencer: scoreboarded stream words and
// result vectors, watchdog boundary, result/timeout race, downstream stall,
// reset in the middle of a frame.
module tb_zynet_frame_sequencer;
    import zynet_seq_pkg::*;

    localparam int WS    = 16;
    localparam int IN_H  = 265;
    localparam int OUT_H = 10;
    localparam int TMO   = 100;
    localparam int CW    = 32;
    localparam int RW    = OUT_H * WS;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    zynet_frame_sequencer_if #(.WORD_SIZE(WS), .OUTPUT_LAYER_HEIGHT(OUT_H), .CNT_WIDTH(CW)) bus ();

    zynet_frame_sequencer #(
        .WORD_SIZE(WS), .INPUT_LAYER_HEIGHT(IN_H), .OUTPUT_LAYER_HEIGHT(OUT_H),
        .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [WS-1:0] exp_q[$];
    logic [RW-1:0] res_q[$];

    logic          snap_start, snap_yumi, snap_sready, snap_nvalid, snap_error;
    logic          snap_busy, snap_res_valid;
    logic [WS-1:0] snap_ndata;
    logic [RW-1:0] snap_res_data;
    logic [CW-1:0] snap_fc;
    logic          up_seen;
    int n_start, n_yumi, n_up, n_xfer, first_c;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven just after the rising edge; outputs are sampled on the
    // falling edge, i.e. the values seen by the next rising edge.
    task automatic tick();
        @(negedge clk);
        snap_start     = bus.net_start_o;
        snap_yumi      = bus.net_yumi_o;
        snap_sready    = bus.s_ready_o;
        snap_nvalid    = bus.net_valid_o;
        snap_ndata     = bus.net_data_o;
        snap_error     = bus.error_o;
        snap_busy      = bus.busy_o;
        snap_res_valid = bus.res_valid_o;
        snap_res_data  = bus.res_data_o;
        snap_fc        = bus.frame_count_o;
        if (snap_start) n_start++;
        if (snap_yumi) n_yumi++;
        up_seen = bus.s_valid_i && snap_sready;
        if (up_seen) n_up++;
        if (snap_nvalid && bus.net_ready_i) begin
            n_xfer++;
            chk("xfer_expected", RW'(exp_q.size() != 0), RW'(1));
            chk("xfer_data", RW'(snap_ndata), RW'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] mk_vec(input logic [WS-1:0] base);
        logic [RW-1:0] v;
        v = '0;
        for (int j = 0; j < OUT_H; j++) v[word_idx(j) +: WS] = base + WS'(j);
        return v;
    endfunction

    task automatic stream_frame(input logic [WS-1:0] base, input int n_offer,
                                input bit alt, input int stop_after);
        int idx;
        exp_q.delete();
        for (int i = 0; i < stop_after && i < n_offer; i++) exp_q.push_back(base + WS'(i));
        n_start = 0; n_yumi = 0; n_up = 0; n_xfer = 0; first_c = -1; idx = 0;
        bus.en_i = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            bus.s_valid_i   = (idx < n_offer);
            bus.s_data_i    = base + WS'(idx);
            bus.net_ready_i = alt ? (c % 2 == 0) : 1'b1;
            tick();
            if (up_seen) begin
                idx++;
                if (first_c < 0) first_c = c;
            end
            if (n_xfer >= stop_after) break;
        end
        chk("stream_count", RW'(n_xfer), RW'(stop_after));
        chk("first_xfer_latency", RW'(first_c), RW'(2));
        chk("start_pulses", RW'(n_start), RW'(1));
        bus.s_valid_i = 1'b0;
    endtask

    task automatic deliver(input int idle, input logic [RW-1:0] v);
        repeat (idle) begin
            bus.net_valid_i = 1'b0;
            tick();
        end
        bus.net_valid_i = 1'b1;
        bus.net_data_i  = v;
        res_q.push_back(v);
        tick();
        chk("yumi_mealy", RW'(snap_yumi), RW'(1));
        chk("no_error_with_result", RW'(snap_error), RW'(0));
        bus.net_valid_i = 1'b0;
        tick();
        chk("res_valid", RW'(snap_res_valid), RW'(1));
        chk("res_data", snap_res_data, res_q.pop_front());
        chk("yumi_pulses", RW'(n_yumi), RW'(1));
    endtask

    task automatic consume(input logic [CW-1:0] fc_exp);
        bus.res_yumi_i = 1'b1;
        tick();
        bus.res_yumi_i = 1'b0;
        tick();
        chk("res_valid_drop", RW'(snap_res_valid), RW'(0));
        chk("frame_count", RW'(snap_fc), RW'(fc_exp));
        chk("idle_after_yumi", RW'(snap_busy), RW'(0));
    endtask

    initial begin
        logic [RW-1:0] v;
        int up0;
        bus.en_i = 0; bus.clear_i = 0; bus.s_data_i = '0; bus.s_valid_i = 0;
        bus.net_ready_i = 0; bus.net_data_i = '0; bus.net_valid_i = 0; bus.res_yumi_i = 0;
        n_start = 0; n_yumi = 0; n_up = 0; n_xfer = 0; first_c = -1;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", RW'(snap_busy), RW'(0));
        chk("rst_error", RW'(snap_error), RW'(0));
        chk("rst_res_valid", RW'(snap_res_valid), RW'(0));
        chk("rst_res_data", snap_res_data, RW'(0));
        chk("rst_frame_count", RW'(snap_fc), RW'(0));
        chk("rst_start", RW'(snap_start), RW'(0));

        // Inputs that must be ignored in IDLE (en_i low)
        bus.net_valid_i = 1; bus.clear_i = 1; bus.res_yumi_i = 1; bus.s_valid_i = 1;
        bus.net_ready_i = 1;
        tick();
        chk("idle_no_yumi", RW'(snap_yumi), RW'(0));
        chk("idle_no_sready", RW'(snap_sready), RW'(0));
        bus.net_valid_i = 0; bus.clear_i = 0; bus.res_yumi_i = 0; bus.s_valid_i = 0;
        tick();
        chk("idle_stays", RW'(snap_busy), RW'(0));
        chk("idle_fc", RW'(snap_fc), RW'(0));

        // Nominal frame
        stream_frame(16'h0000, IN_H, 1'b0, IN_H);
        deliver(39, mk_vec(16'h0001));
        consume(1);

        // Backpressure, upstream offers 300 words
        stream_frame(16'hA000, 300, 1'b1, IN_H);
        up0 = n_up;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 16'hA000 + WS'(IN_H);
        for (int c = 0; c < 20; c++) begin
            bus.net_ready_i = (c % 2 == 0);
            tick();
        end
        chk("no_word_266", RW'(n_up - up0), RW'(0));
        chk("sready_after_frame", RW'(snap_sready), RW'(0));
        bus.s_valid_i = 1'b0;
        bus.net_ready_i = 1'b1;
        deliver(5, mk_vec(16'h0B00));
        consume(2);

        // Watchdog timeout
        stream_frame(16'h1000, IN_H, 1'b0, IN_H);
        bus.s_valid_i = 1'b1;
        for (int t = 1; t <= TMO; t++) begin
            tick();
            if (t == TMO) chk("no_error_at_100", RW'(snap_error), RW'(0));
        end
        tick();
        chk("error_at_101", RW'(snap_error), RW'(1));
        chk("error_sready", RW'(snap_sready), RW'(0));
        chk("error_busy", RW'(snap_busy), RW'(1));
        bus.s_valid_i = 1'b0;
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        tick();
        chk("clear_error", RW'(snap_error), RW'(0));
        chk("clear_idle", RW'(snap_busy), RW'(0));
        chk("clear_fc", RW'(snap_fc), RW'(2));
        chk("timeout_no_yumi", RW'(n_yumi), RW'(0));

        // Result on the terminal watchdog cycle, then downstream stall
        stream_frame(16'h2000, IN_H, 1'b0, IN_H);
        v = mk_vec(16'h5A00);
        deliver(TMO - 1, v);
        bus.s_valid_i = 1'b1;
        bus.net_valid_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("stall_res_valid", RW'(snap_res_valid), RW'(1));
            chk("stall_res_data", snap_res_data, v);
            chk("stall_no_start", RW'(snap_start), RW'(0));
            chk("stall_sready", RW'(snap_sready), RW'(0));
            chk("stall_no_yumi", RW'(snap_yumi), RW'(0));
        end
        bus.net_valid_i = 1'b0;
        bus.res_yumi_i = 1'b1;
        tick();
        bus.res_yumi_i = 1'b0;
        bus.s_valid_i = 1'b0;
        tick();
        chk("no_start_on_yumi", RW'(snap_busy), RW'(0));
        chk("stall_fc", RW'(snap_fc), RW'(3));
        tick();

        // Reset after 100 transfers
        stream_frame(16'h3000, IN_H, 1'b0, 100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_busy", RW'(snap_busy), RW'(0));
        chk("mid_rst_sready", RW'(snap_sready), RW'(0));
        chk("mid_rst_nvalid", RW'(snap_nvalid), RW'(0));
        chk("mid_rst_ndata", RW'(snap_ndata), RW'(0));
        chk("mid_rst_res_data", snap_res_data, RW'(0));
        chk("mid_rst_fc", RW'(snap_fc), RW'(0));
        stream_frame(16'h4000, 300, 1'b0, IN_H);
        up0 = n_up;
        bus.s_valid_i = 1'b1;
        repeat (10) tick();
        chk("post_rst_no_extra", RW'(n_up - up0), RW'(0));
        bus.s_valid_i = 1'b0;
        deliver(3, mk_vec(16'h0C00));
        consume(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zynet_frame_sequencer.md
Name: zynet_frame_sequencer

Overview:
- Frame-level controller that sequences one zyNet inference per input frame.
- Sits between the serialized sample stream and the zyNet core; a downstream consumer sits after it.
- Per frame: pulses the core's start input, gates exactly INPUT_LAYER_HEIGHT words into the core, and waits for the result with a watchdog.
- It then captures the result vector, acknowledges the core (yumi), and holds the result for the consumer.

Parameters:
- WORD_SIZE, 16, bits per sample/result word
- INPUT_LAYER_HEIGHT, 265, words per input frame
- OUTPUT_LAYER_HEIGHT, 10, result words per frame
- TIMEOUT_CYCLES, 65535, max cycles in WAIT before error (≥1)
- CNT_WIDTH, 32, frame counter width

Ports:
- clk_i  in  1  clock, all logic on rising edge
- reset_i  in  1  synchronous active-high reset
- en_i  in  1  allow new frames to start
- clear_i  in  1  leave ERROR state
- s_data_i  in  WORD_SIZE  upstream sample
- s_valid_i  in  1  upstream word valid
- s_ready_o  out  1  upstream word accepted (s_valid_i & s_ready_o)
- net_start_o  out  1  one-cycle start pulse to core
- net_data_o  out  WORD_SIZE  sample to core
- net_valid_o  out  1  sample valid to core
- net_ready_i  in  1  core ready for sample
- net_data_i  in  OUTPUT_LAYER_HEIGHT*WORD_SIZE  core result vector, word j at [j*WORD_SIZE +: WORD_SIZE]
- net_valid_i  in  1  core result valid
- net_yumi_o  out  1  result consumed, to core
- res_data_o  out  OUTPUT_LAYER_HEIGHT*WORD_SIZE  registered result
- res_valid_o  out  1  result available downstream
- res_yumi_i  in  1  downstream consumed result
- busy_o  out  1  state != IDLE
- error_o  out  1  watchdog fired; high in ERROR
- frame_count_o  out  CNT_WIDTH  completed frames, wraps

Behaviour:
- States: IDLE, START, STREAM, WAIT, DELIVER, ERROR.
- Reset: state=IDLE, word count=0, watchdog=0, res_data_o=0, frame_count_o=0; every 1-bit output 0.
- IDLE -> START when en_i & s_valid_i; no upstream word consumed in this cycle.
- START: net_start_o=1 for exactly this one cycle; -> STREAM next cycle.
- STREAM:
  - s_ready_o = net_ready_i; net_valid_o = s_valid_i; net_data_o = s_data_i (combinational pass-through).
  - Transfer occurs when s_valid_i & net_ready_i; word count increments on each transfer.
  - On the transfer where count == INPUT_LAYER_HEIGHT-1: count clears, watchdog clears, -> WAIT.
  - No watchdog in STREAM; upstream stalls are unlimited.
- Outside STREAM: s_ready_o=0, net_valid_o=0, net_data_o=0. A 266th word is never accepted.
- WAIT:
  - Watchdog increments each cycle.
  - If net_valid_i=1: net_yumi_o=1 in the same cycle (Mealy), res_data_o <= net_data_i, -> DELIVER.
  - Else if watchdog == TIMEOUT_CYCLES-1: -> ERROR.
  - net_valid_i and timeout in the same cycle: the result wins; no error.
- DELIVER:
  - res_valid_o=1, held with stable res_data_o until res_yumi_i.
  - On res_yumi_i: frame_count_o increments (modulo 2^CNT_WIDTH), -> IDLE. No new frame starts in that cycle.
- ERROR: error_o=1; -> IDLE on clear_i. No yumi issued; res_data_o keeps its last value.
- Ignored inputs:
  - res_yumi_i when res_valid_o=0.
  - net_valid_i outside WAIT (net_yumi_o stays 0).
  - clear_i outside ERROR.
- en_i deasserted mid-frame only blocks the next IDLE->START; the current frame completes.
- reset_i at any state takes priority: next cycle equals reset state, and a partially streamed frame is abandoned.
- Widths: word count is $clog2(INPUT_LAYER_HEIGHT+1) bits; watchdog is $clog2(TIMEOUT_CYCLES+1) bits.
- Latency: first word can transfer 2 cycles after s_valid_i is seen in IDLE. res_valid_o rises the cycle after net_valid_i is sampled in WAIT.

Decomposition:
- Package zynet_seq_pkg: state enum (seq_state_e), default-parameter constants, and function word_idx(j) returning j*WORD_SIZE.
- One sub-module: zynet_seq_watchdog (clear/enable counter with terminal-count flag, parameter TIMEOUT_CYCLES). The FSM and word counter stay in the top.

Test Plan:
- Nominal:
  - Stimulus: 265 words 0x0000..0x0108, net_ready_i=1, net_valid_i 40 cycles after last transfer with words 0x0001..0x000A, res_yumi_i next cycle.
  - Response: one net_start_o pulse; exactly 265 transfers; net_yumi_o high 1 cycle; res_data_o word j = j+1; frame_count_o=1.
- Backpressure:
  - Stimulus: net_ready_i alternates 1/0, upstream offers 300 words.
  - Response: exactly 265 accepted in order; s_ready_o=0 after the 265th until the next frame.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100, net_valid_i never asserted.
  - Response: error_o=1 on the 101st cycle after entering WAIT; s_ready_o=0; clear_i returns to IDLE with frame_count_o unchanged.
- Race:
  - Stimulus: TIMEOUT_CYCLES=100, net_valid_i asserted on watchdog==99.
  - Response: result captured, net_yumi_o=1, error_o stays 0.
- Downstream stall:
  - Stimulus: res_yumi_i held 0 for 20 cycles while s_valid_i=1.
  - Response: res_valid_o and res_data_o stable; no net_start_o; s_ready_o=0.
- Reset mid-STREAM:
  - Stimulus: reset_i pulsed after 100 transfers.
  - Response: all outputs 0 next cycle; following frame again needs exactly 265 words.
